// File: rtl/lbs_pkg.sv
// Shared definitions for the lookahead-borrow sequential subtractor.
package lbs_pkg;

  // Bits handled by one lookahead-borrow slice per clock.
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibble counter width: max(1, clog2(WIDTH/NIB_W)).
  function automatic int cnt_width(input int width);
    int nib;
    int w;
    nib = width / NIB_W;
    w = 1;
    while ((1 << w) < nib) w++;
    return w;
  endfunction

endpackage

// File: rtl/lbs_4.sv
// Combinational 4-bit lookahead-borrow subtract slice: d = a - b - bi.
// With LBS_OVF_EN defined it also exposes the borrow into bit 3 (b3).
module lbs_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
`ifdef LBS_OVF_EN
  ,
  output logic       b3
`endif
);

  logic [3:0] g;   // bit generates a borrow on its own
  logic [3:0] p;   // bit passes an incoming borrow through
  logic [3:0] br;  // borrow into each bit

  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign g[gi] = ~a[gi] & b[gi];
    assign p[gi] = ~(a[gi] ^ b[gi]);
    assign d[gi] = a[gi] ^ b[gi] ^ br[gi];
  end

  // Every internal borrow is a flat sum of products, no ripple chain.
  assign br[0] = bi;
  assign br[1] = g[0] | (p[0] & bi);
  assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
  assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & bi);
  assign bo    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bi);

`ifdef LBS_OVF_EN
  assign b3 = br[3];
`endif

endmodule

// File: rtl/lbs_seq_sub.sv
// Multi-cycle unsigned subtractor: diff = a - b - bin, one nibble per
// clock, LSB first, through a single shared lbs_4 slice.
// Optional macro LBS_OVF_EN adds the two's-complement overflow output ovf.
module lbs_seq_sub
  import lbs_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef LBS_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = cnt_width(WIDTH);

  if (((WIDTH % NIB_W) != 0) || (WIDTH < NIB_W)) begin : g_width_check
    $error("lbs_seq_sub: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               borrow_reg;
  logic               bout_reg;
  logic               accept;
  logic               last_nib;
  logic [NIB_W-1:0]   a_nib;
  logic [NIB_W-1:0]   b_nib;
  logic [NIB_W-1:0]   slice_d;
  logic               slice_bo;
`ifdef LBS_OVF_EN
  logic               slice_b3;
  logic               ovf_reg;
`endif

  assign accept   = in_valid & in_ready;
  assign last_nib = (cnt_reg == CNT_W'(NIB - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        if (last_nib) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Select the operand nibbles addressed by the counter.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      if (cnt_reg == CNT_W'(i)) begin
        a_nib = a_reg[i*NIB_W +: NIB_W];
        b_nib = b_reg[i*NIB_W +: NIB_W];
      end
    end
  end

  lbs_4 u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .bi (borrow_reg),
    .d  (slice_d),
    .bo (slice_bo)
`ifdef LBS_OVF_EN
    ,
    .b3 (slice_b3)
`endif
  );

  // Operand capture, running borrow, counter and final borrow-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      bout_reg   <= 1'b0;
    end else if (accept) begin
      cnt_reg    <= '0;
      a_reg      <= a_in;
      b_reg      <= b_in;
      borrow_reg <= bin;
    end else if (state_reg == CALC) begin
      cnt_reg    <= cnt_reg + CNT_W'(1);
      borrow_reg <= slice_bo;
      if (last_nib) bout_reg <= slice_bo;
    end
  end

  // One result register per nibble, written when the counter points at it.
  for (genvar gi = 0; gi < NIB; gi++) begin : g_diff
    logic [NIB_W-1:0] nib_reg;

    // Capture this nibble's slice result during its CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        nib_reg <= '0;
      else if ((state_reg == CALC) && (cnt_reg == CNT_W'(gi)))
        nib_reg <= slice_d;
    end

    assign diff[gi*NIB_W +: NIB_W] = nib_reg;
  end

  assign bout = bout_reg;

`ifdef LBS_OVF_EN
  // Overflow is the XOR of the borrows into and out of the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_reg <= 1'b0;
    else if ((state_reg == CALC) && last_nib)
      ovf_reg <= slice_b3 ^ slice_bo;
  end

  assign ovf = ovf_reg;
`endif

endmodule
